prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_if.sv | 19 +
 rtl/prog_loader.sv | 106 ++++++++++
 tb/tb_prog_loader.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte stream in and instruction-memory write port of the program loader
interface prog_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - loads a length-prefixed, XOR-checksummed byte stream into instruction memory
module prog_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 256,
  parameter int          TIMEOUT   = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  prog_loader_if.master bus,
  output logic       cpu_hold,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERR
  } state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t          state, state_nxt;
  logic            active, accept, timed_out, last_word, len_bad, restart;
  logic [15:0]     len_q, len_full, word_cnt;
  logic [7:0]      csum, hi_byte;
  logic [TW-1:0]   idle_cnt;

  assign active    = (state == LEN_HI) || (state == LEN_LO) || (state == DATA_HI) ||
                     (state == DATA_LO) || (state == CHECK);
  assign accept    = active && bus.rx_valid;
  assign restart   = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign timed_out = active && !accept && (idle_cnt == TW'(TIMEOUT - 1));
  assign len_full  = {len_q[15:8], bus.rx_data};
  assign len_bad   = (len_full == 16'd0) || (int'(len_full) > MAX_WORDS);
  assign last_word = (word_cnt == len_q - 16'd1);

  assign bus.rx_ready = active;
  assign cpu_hold     = active || (state == ERR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nxt = LEN_HI;
      LEN_HI:          if (accept) state_nxt = LEN_LO;
      LEN_LO:          if (accept) state_nxt = len_bad ? ERR : DATA_HI;
      DATA_HI:         if (accept) state_nxt = DATA_LO;
      DATA_LO:         if (accept) state_nxt = last_word ? CHECK : DATA_HI;
      CHECK:           if (accept) state_nxt = (bus.rx_data == csum) ? DONE : ERR;
      default:         state_nxt = IDLE;
    endcase
    if (timed_out) state_nxt = ERR;
  end

  // The write strobe is registered, so an async reset in the following cycle kills it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= 16'h0000;
      bus.mem_wdata <= 16'h0000;
      done          <= 1'b0;
      err           <= 1'b0;
      len_q         <= 16'h0000;
      word_cnt      <= 16'h0000;
      csum          <= 8'h00;
      hi_byte       <= 8'h00;
      idle_cnt      <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      if (restart) begin
        done     <= 1'b0;
        err      <= 1'b0;
        word_cnt <= 16'h0000;
        csum     <= 8'h00;
        idle_cnt <= '0;
      end
      if (active) idle_cnt <= accept ? '0 : idle_cnt + TW'(1);
      if (accept) begin
        case (state)
          LEN_HI:  len_q[15:8] <= bus.rx_data;
          LEN_LO:  len_q[7:0]  <= bus.rx_data;
          DATA_HI: begin
            hi_byte <= bus.rx_data;
            csum    <= csum ^ bus.rx_data;
          end
          DATA_LO: begin
            csum          <= csum ^ bus.rx_data;
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= BASE_ADDR + word_cnt;
            bus.mem_wdata <= {hi_byte, bus.rx_data};
            word_cnt      <= word_cnt + 16'd1;
          end
          default: ;
        endcase
      end
      // Each load ends by setting exactly one flag; restart clears both.
      if (active && state_nxt == DONE) done <= 1'b1;
      if (active && state_nxt == ERR)  err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader at base 0x0000 and 0xFFFF
module tb_prog_loader;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       hold0, done0, err0, hold1, done1, err1;

  int checks = 0;
  int failures = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  prog_loader_if if0 ();
  prog_loader_if if1 ();
  assign if0.rx_data  = rx_data;
  assign if0.rx_valid = rx_valid;
  assign if1.rx_data  = rx_data;
  assign if1.rx_valid = rx_valid;

  prog_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(256), .TIMEOUT(TO)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .bus(if0),
    .cpu_hold(hold0), .done(done0), .err(err0));

  prog_loader #(.BASE_ADDR(16'hFFFF), .MAX_WORDS(256), .TIMEOUT(TO)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .bus(if1),
    .cpu_hold(hold1), .done(done1), .err(err1));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe is matched against the head of its queue.
  always @(negedge clk) begin
    if (if0.mem_we === 1'b1) begin
      if (q0.size() == 0) chk("dut0_unexpected_write", {if0.mem_addr, if0.mem_wdata}, 32'hxxxx_xxxx);
      else chk("dut0_write", {if0.mem_addr, if0.mem_wdata}, q0.pop_front());
    end
    if (if1.mem_we === 1'b1) begin
      if (q1.size() == 0) chk("dut1_unexpected_write", {if1.mem_addr, if1.mem_wdata}, 32'hxxxx_xxxx);
      else chk("dut1_write", {if1.mem_addr, if1.mem_wdata}, q1.pop_front());
    end
    if (rst) chk("done_err_exclusive", {30'd0, done0, err0} == 32'd3 ? 32'd1 : 32'd0, 32'd0);
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok = 0;
    repeat (gap) @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 4 * TO && !ok; i++) begin
      @(negedge clk);
      if (if0.rx_ready) begin
        @(posedge clk); #1;
        ok = 1;
      end
    end
    rx_valid = 1'b0;
    if (!ok) chk("rx_ready_wait", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [15:0] w, input logic [15:0] n, input int gap);
    q0.push_back({16'h0000 + n, w});
    q1.push_back({16'hFFFF + n, w});
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  task automatic status(input string name, input logic d, input logic e, input logic h);
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_done0"}, {31'd0, done0}, {31'd0, d});
    chk({name, "_err0"},  {31'd0, err0},  {31'd0, e});
    chk({name, "_hold0"}, {31'd0, hold0}, {31'd0, h});
    chk({name, "_done1"}, {31'd0, done1}, {31'd0, d});
    chk({name, "_err1"},  {31'd0, err1},  {31'd0, e});
  endtask

  task automatic nominal(input int gap, input logic [7:0] cs);
    pulse_start();
    send_byte(8'h00, gap);
    send_byte(8'h02, gap);
    send_word(16'h1234, 16'd0, gap);
    send_word(16'hABCD, 16'd1, gap);
    send_byte(cs, gap);
  endtask

  task automatic reset_outputs(input string name);
    chk({name, "_rx_ready"},  {31'd0, if0.rx_ready}, 32'd0);
    chk({name, "_mem_we"},    {31'd0, if0.mem_we}, 32'd0);
    chk({name, "_mem_addr"},  {16'd0, if0.mem_addr}, 32'd0);
    chk({name, "_mem_wdata"}, {16'd0, if0.mem_wdata}, 32'd0);
    chk({name, "_flags"},     {29'd0, hold0, done0, err0}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset_outputs("reset");
    rst = 1'b1;

    // Bytes offered while idle must be ignored.
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    repeat (4) @(posedge clk);
    #1;
    chk("idle_rx_ready", {31'd0, if0.rx_ready}, 32'd0);
    chk("idle_hold", {31'd0, hold0}, 32'd0);
    rx_valid = 1'b0;

    nominal(0, 8'h40);
    status("nominal", 1'b1, 1'b0, 1'b0);

    nominal(0, 8'h41);
    status("bad_csum", 1'b0, 1'b1, 1'b1);
    chk("bad_csum_rx_ready", {31'd0, if0.rx_ready}, 32'd0);

    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    status("len_zero", 1'b0, 1'b1, 1'b1);

    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    status("len_257", 1'b0, 1'b1, 1'b1);

    nominal(5, 8'h40);
    status("backpressure", 1'b1, 1'b0, 1'b0);

    // Timeout mid-word: still loading after TO-1 idle cycles, ERR after TO.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    repeat (TO - 1) @(posedge clk);
    #1;
    chk("timeout_minus1_ready", {31'd0, if0.rx_ready}, 32'd1);
    chk("timeout_minus1_err", {31'd0, err0}, 32'd0);
    @(posedge clk); #1;
    chk("timeout_ready", {31'd0, if0.rx_ready}, 32'd0);
    chk("timeout_err", {31'd0, err0}, 32'd1);
    chk("timeout_hold", {31'd0, hold0}, 32'd1);

    // Reset in the cycle where word 0's write strobe is due.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'h55, 0);
    send_byte(8'h66, 0);
    rst = 1'b0;
    #1;
    reset_outputs("midload_reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset_outputs("after_reset");

    // Restart from DONE.
    nominal(0, 8'h40);
    status("pre_restart", 1'b1, 1'b0, 1'b0);
    pulse_start();
    chk("restart_done_clear", {31'd0, done0}, 32'd0);
    chk("restart_hold", {31'd0, hold0}, 32'd1);
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    send_word(16'h1111, 16'd0, 0);
    send_word(16'h2233, 16'd1, 0);
    send_byte(8'h11, 0);
    status("restart", 1'b1, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
